// File: rtl/fetch_issue.sv
// fetch_issue: instruction fetch front end.
// It holds the fetch PC, issues in-order word fetches to instruction memory
// and keeps a small circular buffer of slots. Each slot is allocated at
// request time and filled by the in-order response. The oldest filled slot
// is presented to decode from registers. A redirect flushes the buffer, and
// responses that are still in flight are counted so they can be discarded.
module fetch_issue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]            pc_q;
    logic [PW-1:0]          head_q, tail_q, fill_q;
    logic [CW-1:0]          used_q;   // allocated slots, filled or not
    logic [CW-1:0]          pend_q;   // allocated slots still waiting for data
    logic [CW-1:0]          drop_q;   // in-flight responses orphaned by a redirect
    logic [DEPTH-1:0][31:0] slot_pc_q;
    logic [DEPTH-1:0][31:0] slot_inst_q;
    logic [DEPTH-1:0]       slot_full_q;

    logic        req_hs, pop, rsp_drop, rsp_fill, rsp_old;
    logic [CW:0] credit;
    logic        unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    // Orphaned responses still hold a slot's worth of credit. This keeps the
    // number of in-flight responses bounded by DEPTH.
    assign credit         = {1'b0, used_q} + {1'b0, drop_q};
    assign imem_req_valid = (credit < DEPTH_C) & ~redirect_valid & ~rst;
    assign imem_req_addr  = pc_q;
    assign req_hs         = imem_req_valid & imem_req_ready;

    // The decode-facing outputs come only from slot registers.
    assign valid_o = slot_full_q[head_q];
    assign pc_o    = slot_pc_q[head_q];
    assign inst_o  = slot_inst_q[head_q];
    assign pop     = valid_o & ready_i;

    // Pay off orphaned responses first. A response with nothing to fill
    // and nothing to drop is ignored.
    assign rsp_drop = imem_rsp_valid & (drop_q != '0);
    assign rsp_fill = imem_rsp_valid & (drop_q == '0) & (pend_q != '0);
    assign rsp_old  = rsp_drop | rsp_fill;

    // Fetch PC, slot pointers, occupancy counters and slot storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            used_q      <= '0;
            pend_q      <= '0;
            drop_q      <= '0;
            slot_pc_q   <= '0;
            slot_inst_q <= '0;
            slot_full_q <= '0;
        end else if (redirect_valid) begin
            // Every request that is still outstanding becomes a drop. A
            // response in this same cycle belongs to the old stream, so it
            // retires one of those drops now.
            pc_q        <= {redirect_pc[31:2], 2'b00};
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            used_q      <= '0;
            pend_q      <= '0;
            drop_q      <= drop_q + pend_q - CW'(rsp_old);
            slot_full_q <= '0;
        end else begin
            if (req_hs) begin
                pc_q              <= pc_q + 32'd4;
                slot_pc_q[tail_q] <= pc_q;
                tail_q            <= tail_q + PW'(1);
            end
            if (rsp_fill) begin
                slot_inst_q[fill_q] <= imem_rsp_data;
                slot_full_q[fill_q] <= 1'b1;
                fill_q              <= fill_q + PW'(1);
            end
            if (pop) begin
                slot_full_q[head_q] <= 1'b0;
                head_q              <= head_q + PW'(1);
            end
            if (rsp_drop)
                drop_q <= drop_q - CW'(1);
            case ({req_hs, pop})
                2'b10:   used_q <= used_q + CW'(1);
                2'b01:   used_q <= used_q - CW'(1);
                default: used_q <= used_q;
            endcase
            case ({req_hs, rsp_fill})
                2'b10:   pend_q <= pend_q + CW'(1);
                2'b01:   pend_q <= pend_q - CW'(1);
                default: pend_q <= pend_q;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_issue.sv
// Directed bench for fetch_issue. u_d2 is DEPTH=2 and carries most scenarios.
// u_d4 is DEPTH=4, which leaves enough slots to stream one instruction per cycle.
// The instruction memory is modelled in tick(): in auto mode, an accepted
// request is answered one cycle later with data = addr ^ KEY.
module tb_fetch_issue;
    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        ready_i = 1'b0;

    logic        rv2, v2, rv4, v4;
    logic [31:0] ra2, pc2, in2, ra4, pc4, in4;

    int n_chk = 0;
    int n_fail = 0;
    int hs_cnt = 0;
    bit sel4 = 1'b0;
    bit auto_mem = 1'b1;

    always #5 clk = ~clk;

    fetch_issue #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(rv2), .imem_req_ready(imem_req_ready), .imem_req_addr(ra2),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .valid_o(v2), .ready_i(ready_i), .pc_o(pc2), .inst_o(in2));

    fetch_issue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(rv4), .imem_req_ready(imem_req_ready), .imem_req_addr(ra4),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .valid_o(v4), .ready_i(ready_i), .pc_o(pc4), .inst_o(in4));

    // One clock cycle. It samples the request handshake of the selected DUT
    // before the edge and, in auto mode, presents the response after the edge.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        #1;
        hs = sel4 ? (rv4 & imem_req_ready) : (rv2 & imem_req_ready);
        a  = sel4 ? ra4 : ra2;
        if (hs) hs_cnt++;
        @(posedge clk);
        #1;
        imem_rsp_valid = auto_mem & hs;
        imem_rsp_data  = (auto_mem & hs) ? (a ^ KEY) : 32'h0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; imem_rsp_valid = 1'b0; ready_i = 1'b0;
        imem_req_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; hs_cnt = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_chk++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL reset_valid_o: got %b want 0", v2); end
        n_chk++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", rv2); end
        n_chk++; if (pc2 !== 32'h0) begin n_fail++; $display("FAIL reset_pc_o: got %h want 0", pc2); end
        n_chk++; if (in2 !== 32'h0) begin n_fail++; $display("FAIL reset_inst_o: got %h want 0", in2); end
        rst = 1'b0;
        #1;
        n_chk++; if (rv2 !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b want 1", rv2); end
        n_chk++; if (ra2 !== 32'h0) begin n_fail++; $display("FAIL first_req_addr: got %h want 0", ra2); end
    endtask

    task automatic test_stream();
        sel4 = 1'b1; auto_mem = 1'b1;
        do_reset();
        ready_i = 1'b1;
        tick();
        n_chk++; if (v4 !== 1'b0) begin n_fail++; $display("FAIL stream_latency: valid_o got %b want 0", v4); end
        tick();
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (v4 !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, v4); end
            n_chk++; if (pc4 !== 32'(i * 4)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pc4, 32'(i * 4)); end
            n_chk++; if (in4 !== (32'(i * 4) ^ KEY)) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h want %h", i, in4, 32'(i * 4) ^ KEY); end
            tick();
        end
        sel4 = 1'b0;
    endtask

    task automatic test_backpressure();
        auto_mem = 1'b1;
        do_reset();
        ready_i = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (v2 !== 1'b1 || pc2 !== 32'h0) begin n_fail++; $display("FAIL bp_hold[%0d]: valid %b pc %h want 1 0", i, v2, pc2); end
            tick();
        end
        n_chk++; if (hs_cnt !== 2) begin n_fail++; $display("FAIL bp_req_count: got %0d want 2", hs_cnt); end
        n_chk++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b want 0", rv2); end
        ready_i = 1'b1;
        tick();
        n_chk++; if (v2 !== 1'b1 || pc2 !== 32'h4) begin n_fail++; $display("FAIL bp_release: valid %b pc %h want 1 4", v2, pc2); end
        n_chk++; if (in2 !== (32'h4 ^ KEY)) begin n_fail++; $display("FAIL bp_release_inst: got %h want %h", in2, 32'h4 ^ KEY); end
    endtask

    task automatic test_redirect();
        auto_mem = 1'b0;
        do_reset();
        ready_i = 1'b1;
        tick(); tick();
        n_chk++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL redir_full: req_valid got %b want 0", rv2); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_chk++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL redir_flush: valid_o got %b want 0", v2); end
        n_chk++; if (ra2 !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got %h want 100", ra2); end
        n_chk++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL redir_credit: req_valid got %b want 0", rv2); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0000;
        tick();
        n_chk++; if (v2 !== 1'b0 || rv2 !== 1'b1) begin n_fail++; $display("FAIL redir_drop1: valid %b req %b want 0 1", v2, rv2); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0004;
        tick();
        n_chk++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL redir_drop2: valid_o got %b want 0", v2); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h100 ^ KEY;
        tick();
        n_chk++; if (v2 !== 1'b1 || pc2 !== 32'h100) begin n_fail++; $display("FAIL redir_first: valid %b pc %h want 1 100", v2, pc2); end
        n_chk++; if (in2 !== (32'h100 ^ KEY)) begin n_fail++; $display("FAIL redir_inst: got %h want %h", in2, 32'h100 ^ KEY); end
        n_chk++; if (hs_cnt !== 4) begin n_fail++; $display("FAIL redir_req_count: got %0d want 4", hs_cnt); end
        auto_mem = 1'b1;
    endtask

    task automatic test_coincident();
        auto_mem = 1'b1;
        do_reset();
        ready_i = 1'b0;
        tick(); tick();
        n_chk++; if (v2 !== 1'b1 || pc2 !== 32'h0) begin n_fail++; $display("FAIL coin_pre: valid %b pc %h want 1 0", v2, pc2); end
        ready_i = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_chk++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL coin_flush: valid_o got %b want 0", v2); end
        n_chk++; if (rv2 !== 1'b1 || ra2 !== 32'h200) begin n_fail++; $display("FAIL coin_req: valid %b addr %h want 1 200", rv2, ra2); end
        tick();
        n_chk++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL coin_wait: valid_o got %b want 0", v2); end
        tick();
        n_chk++; if (v2 !== 1'b1 || pc2 !== 32'h200) begin n_fail++; $display("FAIL coin_first: valid %b pc %h want 1 200", v2, pc2); end
        tick();
        n_chk++; if (v2 !== 1'b1 || pc2 !== 32'h204) begin n_fail++; $display("FAIL coin_second: valid %b pc %h want 1 204", v2, pc2); end
        n_chk++; if (hs_cnt !== 4) begin n_fail++; $display("FAIL coin_req_count: got %0d want 4", hs_cnt); end
    endtask

    task automatic test_wrap();
        auto_mem = 1'b1;
        do_reset();
        ready_i = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_chk++; if (rv2 !== 1'b1 || ra2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req: valid %b addr %h want 1 fffffffc", rv2, ra2); end
        tick(); tick();
        n_chk++; if (v2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc0: valid %b pc %h want 1 fffffffc", v2, pc2); end
        tick();
        n_chk++; if (v2 !== 1'b1 || pc2 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc1: valid %b pc %h want 1 0", v2, pc2); end
        n_chk++; if (in2 !== KEY) begin n_fail++; $display("FAIL wrap_inst1: got %h want %h", in2, KEY); end
        n_chk++; if (ra2 !== 32'h4) begin n_fail++; $display("FAIL wrap_next_addr: got %h want 4", ra2); end
    endtask

    task automatic test_stray_rsp();
        auto_mem = 1'b0;
        do_reset();
        ready_i = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        tick();
        n_chk++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL stray_ignored: valid_o got %b want 0", v2); end
        imem_req_ready = 1'b1;
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = KEY;
        tick();
        n_chk++; if (v2 !== 1'b1 || pc2 !== 32'h0 || in2 !== KEY) begin n_fail++; $display("FAIL stray_after: valid %b pc %h inst %h want 1 0 %h", v2, pc2, in2, KEY); end
        auto_mem = 1'b1;
    endtask

    task automatic test_async_reset();
        auto_mem = 1'b1;
        do_reset();
        ready_i = 1'b1;
        tick(); tick(); tick();
        n_chk++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL arst_pre: valid_o got %b want 1", v2); end
        rst = 1'b1; imem_rsp_valid = 1'b0;
        #1;
        n_chk++; if (v2 !== 1'b0 || rv2 !== 1'b0) begin n_fail++; $display("FAIL arst_now: valid %b req %b want 0 0", v2, rv2); end
        n_chk++; if (pc2 !== 32'h0) begin n_fail++; $display("FAIL arst_pc: got %h want 0", pc2); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_chk++; if (rv2 !== 1'b1 || ra2 !== 32'h0) begin n_fail++; $display("FAIL arst_release: valid %b addr %h want 1 0", rv2, ra2); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_coincident();
        test_wrap();
        test_stray_rsp();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_issue.md
FETCH_ISSUE -- requirements
Module: fetch_issue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, number of instruction slots (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port redirect_valid  input  1  flush request from a later stage (branch/trap).
REQ-006 SHALL have port redirect_pc  input  32  new fetch address when redirect_valid=1.
REQ-007 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-008 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-009 SHALL have port imem_req_addr  output  32  fetch address, word aligned.
REQ-010 SHALL have port imem_rsp_valid  input  1  in-order read data valid; cannot be back-pressured.
REQ-011 SHALL have port imem_rsp_data  input  32  instruction word.
REQ-012 SHALL have port valid_o  output  1  instruction available to decode stage.
REQ-013 SHALL have port ready_i  input  1  decode stage accepts (decode asserts ready = ~valid | downstream ready).
REQ-014 SHALL have port pc_o  output  32  address of presented instruction.
REQ-015 SHALL have port inst_o  output  32  presented instruction word.

Function
REQ-016 SHALL hold a fetch PC register; request handshake = imem_req_valid & imem_req_ready; on handshake PC <= PC+4, wrapping modulo 2^32.
REQ-017 SHALL keep a circular slot buffer of DEPTH entries {pc, inst, filled}; a slot is allocated with the current PC at request handshake, filled in order on imem_rsp_valid.
REQ-018 SHALL drive imem_req_valid = (used + drop_cnt < DEPTH) & ~redirect_valid; imem_req_addr = PC; request valid and address SHALL stay stable while valid & ~ready.
REQ-019 SHALL drive valid_o = head slot filled; pc_o/inst_o = head slot contents; all three from registers, no combinational path from imem_rsp_* or ready_i.
REQ-020 SHALL pop the head slot on output handshake valid_o & ready_i; pc_o/inst_o SHALL not change while valid_o & ~ready_i (absent redirect).
REQ-021 SHALL show response of cycle N on valid_o in cycle N+1 earliest (1-cycle latency); sustain 1 instruction/cycle when memory returns data 1 cycle after accept.
REQ-022 SHALL, on redirect_valid=1: free all slots, set PC <= {redirect_pc[31:2],2'b00}, set drop_cnt <= number of requested-but-unfilled slots, next cycle valid_o=0.
REQ-023 SHALL discard responses while drop_cnt>0, decrementing drop_cnt per response; drop_cnt slots count against credit (REQ-018).
REQ-024 SHALL treat a response arriving in the same cycle as redirect_valid as old: it is discarded and not counted in the new drop_cnt.
REQ-025 SHALL treat an output handshake in the same cycle as redirect_valid as completed; redirect still flushes remaining slots.
REQ-026 SHALL, with buffer full (used=DEPTH), deassert imem_req_valid; simultaneous pop and request handshake in one cycle SHALL be permitted when used<DEPTH before the edge.
REQ-027 SHALL ignore imem_rsp_valid with no unfilled slot and drop_cnt=0 (protocol error, no state change).
REQ-028 SHALL wrap slot pointers modulo DEPTH without loss or duplication.

Reset
REQ-029 SHALL on rst: PC=RESET_PC, used=0, drop_cnt=0, all slots unfilled, valid_o=0, imem_req_valid=0 during rst, pc_o=0, inst_o=0.
REQ-030 SHALL drive imem_req_valid=1 with imem_req_addr=RESET_PC in the first cycle after rst deasserts.
REQ-031 SHALL, on rst mid-operation, abandon all outstanding requests; the memory side SHALL be reset concurrently.

Verification
REQ-032 Streaming: req_ready=1, 1-cycle rsp, ready_i=1 -> pc_o 0x0,0x4,0x8,... one per cycle after 2-cycle startup.
REQ-033 Backpressure: ready_i=0 for 5 cycles with DEPTH=2 -> valid_o=1, pc_o=0x0 held, exactly 2 requests issued, then imem_req_valid=0.
REQ-034 Redirect with 2 outstanding, redirect_pc=0x103 -> next request addr 0x100, both old responses dropped, first valid_o has pc_o=0x100.
REQ-035 Redirect coincident with response and output handshake -> old response dropped, handshake counted once, no stale pc_o after.
REQ-036 PC wrap: redirect_pc=0xFFFF_FFFC -> consecutive pc_o 0xFFFF_FFFC, 0x0000_0000.
REQ-037 Async rst asserted mid-stream -> valid_o, imem_req_valid low immediately; after release first addr = RESET_PC.
